// File: rtl/store_checker.sv
// Hardware end-of-run judge for the single-cycle MIPS core. It watches the
// data-memory store port and latches a pass, bad-store or timeout verdict.
module store_checker #(
  parameter logic [31:0] PASS_ADDR  = 32'd84,
  parameter logic [31:0] PASS_DATA  = 32'd7,
  parameter logic [31:0] ALLOW_ADDR = 32'd80,
  parameter int          TIMEOUT    = 1024,
  parameter int          CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memwrite,
  input  logic [31:0]      dataadr,
  input  logic [31:0]      writedata,
  output logic [1:0]       status,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] store_cnt,
  output logic [31:0]      last_data,
  output logic [31:0]      bad_addr,
  output logic [31:0]      bad_data,
  output logic [15:0]      cycles
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RUN  = 2'b00,
    S_PASS = 2'b01,
    S_BAD  = 2'b10,
    S_TMO  = 2'b11
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_capture;
  logic [WD_W-1:0]  r_wdog;
  logic [CNT_W-1:0] r_store_cnt;
  logic [31:0]      r_last_data;
  logic [31:0]      r_bad_addr;
  logic [31:0]      r_bad_data;
  logic [15:0]      r_cycles;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  // Equality tests fall through to BAD when an operand is unknown, so X/Z on
  // the store port never produces a pass.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    if (r_state == S_RUN) begin
      if (memwrite) begin
        if (dataadr == PASS_ADDR) begin
          w_capture = 1'b1;
          if (writedata == PASS_DATA) begin
            w_next = S_PASS;
          end else begin
            w_next = S_BAD;
          end
        end else if (dataadr == ALLOW_ADDR) begin
          w_accept = 1'b1;
        end else begin
          w_capture = 1'b1;
          w_next    = S_BAD;
        end
      end
      if (!w_capture && (r_wdog == WD_LAST)) begin
        w_next = S_TMO;
      end
    end
  end

  always_comb begin
    status = r_state;
    done   = (r_state != S_RUN);
    pass   = (r_state == S_PASS);
  end

  // Counters and capture registers only move while running, which freezes
  // every output once a verdict is reached.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wdog      <= '0;
      r_store_cnt <= '0;
      r_last_data <= '0;
      r_bad_addr  <= '0;
      r_bad_data  <= '0;
      r_cycles    <= '0;
    end else if (r_state == S_RUN) begin
      if (r_wdog != WD_LAST) begin
        r_wdog <= r_wdog + WD_W'(1);
      end
      if ((w_next == S_RUN) && (r_cycles != 16'hFFFF)) begin
        r_cycles <= r_cycles + 16'd1;
      end
      if (w_accept) begin
        r_last_data <= writedata;
        if (r_store_cnt != {CNT_W{1'b1}}) begin
          r_store_cnt <= r_store_cnt + CNT_W'(1);
        end
      end
      if (w_capture) begin
        r_bad_addr <= dataadr;
        r_bad_data <= writedata;
      end
    end
  end

  assign store_cnt = r_store_cnt;
  assign last_data = r_last_data;
  assign bad_addr  = r_bad_addr;
  assign bad_data  = r_bad_data;
  assign cycles    = r_cycles;

endmodule

// File: doc/store_checker.md
# store_checker

Synthesizable end-of-run judge that sits beside the single-cycle MIPS `top` and observes its data-memory store port (`memwrite`, `dataadr`, `writedata`). It applies the same pass/fail rule the simulation bench prints, but in hardware, with a watchdog, so on-board runs report pass or fail on LEDs. It is a pure observer: it never drives the CPU or the memory.

## Interface
- `PASS_ADDR`, 84: store address that ends the run.
- `PASS_DATA`, 7: value required at `PASS_ADDR` for a pass.
- `ALLOW_ADDR`, 80: the only other address stores may target during the run.
- `TIMEOUT`, 1024: number of cycles allowed before a verdict; at least 2.
- `CNT_W`, 8: width of the store counter.

- `clk` in 1: CPU clock; all sampling on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `memwrite` in 1: CPU store strobe.
- `dataadr` in 32: store byte address.
- `writedata` in 32: store data.
- `status` out 2: 00 running, 01 pass, 10 bad store, 11 timeout.
- `done` out 1: high when `status` != 00.
- `pass` out 1: high when `status` == 01.
- `store_cnt` out CNT_W: number of accepted stores to `ALLOW_ADDR`, saturating.
- `last_data` out 32: data of the most recent accepted `ALLOW_ADDR` store.
- `bad_addr` out 32: address captured on a bad store or on the terminating store.
- `bad_data` out 32: data captured on a bad store or on the terminating store.
- `cycles` out 16: cycle count at the verdict; live count while running.

## Operation
- States: RUN, PASS, BAD, TMO. Reset enters RUN. PASS, BAD and TMO are terminal and are left only by reset.
- In RUN, each rising edge with `memwrite`=1 is classified. Comparisons use `===`-equivalent exact 32-bit equality. X or Z on the inputs counts as a mismatch in simulation.
  - `dataadr`==PASS_ADDR and `writedata`==PASS_DATA: go to PASS and capture the address and data.
  - `dataadr`==PASS_ADDR with any other data: go to BAD and capture.
  - `dataadr`==ALLOW_ADDR: stay in RUN. `store_cnt`+1, saturating at 2^CNT_W−1. `last_data`<=`writedata`.
  - Any other address: go to BAD and capture.
- In RUN with `memwrite`=0: no classification. `cycles` increments, saturating at 16'hFFFF.
- Watchdog: an internal counter clears at reset and increments every RUN cycle. When it reaches TIMEOUT−1 with no verdict in that cycle, go to TMO; the capture registers stay 0.
- Simultaneous events: a store verdict in the same cycle the watchdog expires takes priority over TMO.
- In a terminal state, all outputs freeze and further `memwrite` pulses are ignored.

## Timing
- Reset values: `status`=00, `done`=0, `pass`=0, `store_cnt`=0, `last_data`=0, `bad_addr`=0, `bad_data`=0, `cycles`=0, watchdog=0.
- Asserting `rst` low mid-run clears everything immediately, without waiting for a clock edge.
- Verdict latency: `status`, `done` and the capture registers update on the same rising edge that samples the deciding store. They are visible one cycle after the store is presented.
- `cycles` at the verdict equals the number of RUN edges before the deciding edge.
- All outputs are registered; there is no combinational path from the inputs to any output.
- TMO asserts on the TIMEOUT-th rising edge after reset release.

## Test plan
- Stores 80←7, then 84←7: after the second edge `status`=01, `pass`=1, `store_cnt`=1, `last_data`=7, `bad_addr`=84, `bad_data`=7.
- Store 84←5: `status`=10 on that edge, `bad_addr`=84, `bad_data`=5; a later 84←7 leaves `status` at 10.
- Store 80←1, then 88←3: `status`=10, `bad_addr`=88, `bad_data`=3, `store_cnt`=1.
- With TIMEOUT=16 and no stores: `status`=11 after exactly 16 edges, `cycles`=15; `bad_addr`=0 and `bad_data`=0.
- With TIMEOUT=16, store 84←7 on edge 16: `status`=01, not 11.
- 300 stores to address 80 with CNT_W=8: `store_cnt` saturates at 255. Dropping `rst` mid-run clears all outputs to 0 without a clock edge.
